// File: rtl/nsa_pkg.sv
// nsa_pkg: shared types and constants for the nibble-serial adder.
// Holds the FSM state encoding and the adder-core nibble width.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_rca4.sv
// rca4_nibble: combinational 4-bit ripple-carry adder of full adders.
// Ports: a, b, cin in; s, cout out. nsa_full_adder is one bit cell.
module nsa_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module rca4_nibble
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;
  assign cout = c[NIBBLE_W];

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    nsa_full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit add, one nibble per clock, one 4-bit RCA.
// In: clk, rst, start, a, b, cin. Out: ready, busy, done, sum, cout.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                     cin,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                     cout
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          carry;
  logic [IW-1:0] idx;

  logic                accept;
  logic                last;
  int                  base;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_c;

  assign accept = (state == IDLE) && start;
  assign last   = (idx == LAST);
  assign base   = int'(idx) * NIBBLE_W;
  assign nib_a  = op_a[base +: NIBBLE_W];
  assign nib_b  = op_b[base +: NIBBLE_W];

  rca4_nibble u_rca (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE): if (start) state_nxt = ADD;
      (state == ADD):  if (last)  state_nxt = DONE;
      (state == DONE): state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (1'b1)
      (state == IDLE): ready = 1'b1;
      (state == ADD):  busy  = 1'b1;
      (state == DONE): done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b;
      carry <= cin;
      idx   <= '0;
    end else if (state == ADD) begin
      sum[base +: NIBBLE_W] <= nib_s;
      carry <= nib_c;
      if (last) cout <= nib_c;
      else      idx  <= idx + IW'(1);
    end
  end

endmodule
